fft_stage_ctrl: RTL and testbench
=================================

# fft_stage_ctrl

Per-stage sequencer for the 32-point, 4-bank in-place FFT datapath. On each stage request it generates the shared read and write addresses for bank pairs 0/1 and 2/3, the bank-input, PE-input and PE-output mux selects, and a write-valid strobe. It signals `stage_done` once the stage's last result has been written. It sits between the top-level stage FSM and the RAM banks, PE and mux network.

## Interface
- `NUMSTAGES`, default 5: number of FFT stages; `stage_num` values at or above this are illegal.
- `ADDRSIZE`, default 3: bank address width; each bank holds 2^ADDRSIZE = 8 words.
- `LAT`, default 2: read-to-write pipeline latency in cycles (address register plus RAM read register).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `ld_data` in 1: RAM load in progress; aborts any stage run and forces input routing.
- `en_stage` in 1: level-sensitive stage request.
- `stage_num` in 3: stage index, sampled at start.
- `m0_s` out 1: bank-input select; 0 = external `data_in`, 1 = PE results.
- `m1_s` out 2: PE-input permutation; 00 = banks (0,1,2,3), 01 = (2,0,3,1), 10 = (0,2,1,3).
- `m2_s` out 1: PE-output swap; 1 = straight, 0 = swap halves.
- `m3_s` out 1: write-valid; high while `w_addr_*` carries a valid result address.
- `r_addr_0_1`, `r_addr_2_3` out ADDRSIZE: read addresses.
- `w_addr_0_1`, `w_addr_2_3` out ADDRSIZE: write addresses.
- `stage_done` out 1: stage complete; held until `en_stage` falls.

## Operation
- FSM states:
  - IDLE: waits for `en_stage`=1 and `ld_data`=0, latches `stage_num` into `s`, clears `k`, goes to RUN.
  - RUN: `k` = 0..7, then DRAIN.
  - DRAIN: LAT cycles, then DONE.
  - DONE: leaves for IDLE when `en_stage`=0.
- Every stage processes 16 butterflies as two per cycle over 8 cycles.
- Both read addresses equal `k`.
- Write addresses equal the read addresses delayed LAT cycles through a shift register, with a valid bit that drives `m3_s`.
- Per-stage selects, constant for the whole run:
  - s=0: `m1_s`=00, `m2_s`=1.
  - s=1: `m1_s`=01, `m2_s`=1.
  - s=2: `m1_s`=10, `m2_s`=1.
  - s=3: `m1_s`=00, `m2_s`=0.
  - s=4: `m1_s`=01, `m2_s`=0.
- `m0_s`=1 in RUN, DRAIN and DONE; 0 in IDLE or whenever `ld_data`=1.
- Illegal `stage_num` (≥ NUMSTAGES): go IDLE→DONE directly; `m3_s` never asserts; selects stay 00/1.
- `ld_data`=1 in any state: next state IDLE, pipeline valid bits cleared, `stage_done`=0.
- `en_stage` falling in RUN or DRAIN: abort to IDLE next edge; valid bits cleared; no `stage_done`.
- Address counter wraps 7→0 only implicitly, because RUN exits after `k`=7.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, valid pipeline cleared.
- Edge E0 samples `en_stage`=1 in IDLE. After E0+j (j=0..7), `r_addr`=j; `m0_s`=1 from E0.
- After E(j+LAT), `w_addr`=j and `m3_s`=1, for j=0..7, i.e. E2..E9. `m3_s`=0 after E10.
- `stage_done`=1 after E(8+LAT)=E10, held while `en_stage`=1.
- Edge seeing `en_stage`=0 in DONE: `stage_done`=0 and `m0_s`=0 after it.
- A new `en_stage`=1 in IDLE restarts at the next edge with a fresh `stage_num`.
- Read addresses after RUN hold 7; write addresses hold 7 after the last write.
- Stage turnaround with the top-level handshake is at least 13 cycles per stage; 5 stages take ≤ 70 cycles.

## Test plan
- Reset mid-RUN (assert `rst` asynchronously after E4) → all outputs 0 immediately, state IDLE, no `stage_done` after release.
- `stage_num`=0, `en_stage` held → `r_addr` 0..7 after E0..E7; `w_addr` 0..7 with `m3_s`=1 after E2..E9; `stage_done`=1 after E10; `m1_s`=00, `m2_s`=1, `m0_s`=1.
- Five back-to-back stages with handshake (drop `en_stage` one cycle after `stage_done`, raise next cycle, `stage_num` 0..4) → `m1_s`/`m2_s` sequence 00/1, 01/1, 10/1, 00/0, 01/0; exactly 40 `m3_s` cycles total.
- `en_stage` dropped at E5 → IDLE next edge, `m3_s` low within 1 cycle, `stage_done` never asserts.
- `ld_data`=1 during DRAIN → `m0_s`=0, `m3_s`=0, `stage_done`=0 next edge; no restart while `ld_data` is high.
- `stage_num`=6 → `stage_done`=1 after E0, `m3_s` stays 0.

Source files
------------

// File: rtl/fft_stage_ctrl_if.sv
// Handshake and control bundle between the stage FSM, the per-stage sequencer
// and the RAM/PE/mux network of the 32-point FFT datapath.
interface fft_stage_ctrl_if #(
    parameter int ADDRSIZE = 3
);
    logic                ld_data;
    logic                en_stage;
    logic [2:0]          stage_num;
    logic                m0_s;
    logic [1:0]          m1_s;
    logic                m2_s;
    logic                m3_s;
    logic [ADDRSIZE-1:0] r_addr_0_1;
    logic [ADDRSIZE-1:0] r_addr_2_3;
    logic [ADDRSIZE-1:0] w_addr_0_1;
    logic [ADDRSIZE-1:0] w_addr_2_3;
    logic                stage_done;

    modport master (
        output ld_data, en_stage, stage_num,
        input  m0_s, m1_s, m2_s, m3_s, r_addr_0_1, r_addr_2_3,
               w_addr_0_1, w_addr_2_3, stage_done
    );

    modport slave (
        input  ld_data, en_stage, stage_num,
        output m0_s, m1_s, m2_s, m3_s, r_addr_0_1, r_addr_2_3,
               w_addr_0_1, w_addr_2_3, stage_done
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Per-stage sequencer: walks k=0..7 over both bank pairs, delays the address by
// the read latency to form the write address/strobe, and raises stage_done.
module fft_stage_ctrl #(
    parameter int NUMSTAGES = 5,
    parameter int ADDRSIZE  = 3,
    parameter int LAT       = 2
) (
    input  logic               clk,
    input  logic               rst,
    fft_stage_ctrl_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int                DW       = $clog2(LAT) + 1;
    localparam logic [DW-1:0]     DRN_LAST = DW'(LAT - 1);
    localparam logic [ADDRSIZE-1:0] K_LAST = '1;

    logic [1:0]                      state_q, state_d;
    logic [DW-1:0]                   drn_q, drn_d;
    logic [1:0]                      m1_s_q, m1_s_d;
    logic                            m2_s_q, m2_s_d;
    logic                            m0_s_q, m0_s_d;
    logic                            stage_done_q, stage_done_d;
    logic [ADDRSIZE-1:0]             k_d;
    logic                            flush;
    // Entry 0 is the live read address; entry LAT is the write address.
    logic [LAT:0][ADDRSIZE-1:0]      addr_pipe_q, addr_pipe_d;
    logic [LAT:0]                    vld_pipe_q, vld_pipe_d;

    always_comb begin
        state_d = state_q;
        drn_d   = drn_q;
        m1_s_d  = m1_s_q;
        m2_s_d  = m2_s_q;
        k_d     = addr_pipe_q[0];
        flush   = 1'b0;
        case (state_q)
            IDLE: if (bus.en_stage && !bus.ld_data) begin
                if (int'(bus.stage_num) < NUMSTAGES) begin
                    state_d = RUN;
                    k_d     = '0;
                    m1_s_d  = (bus.stage_num == 3'd1 || bus.stage_num == 3'd4) ? 2'b01 :
                              (bus.stage_num == 3'd2) ? 2'b10 : 2'b00;
                    m2_s_d  = (bus.stage_num < 3'd3);
                end else begin
                    // Illegal stage: report done without touching the banks.
                    state_d = DONE;
                    m1_s_d  = 2'b00;
                    m2_s_d  = 1'b1;
                end
            end
            RUN: if (!bus.en_stage) begin
                state_d = IDLE;
                flush   = 1'b1;
            end else if (addr_pipe_q[0] == K_LAST) begin
                state_d = DRAIN;
                drn_d   = '0;
            end else begin
                k_d = addr_pipe_q[0] + 1'b1;
            end
            DRAIN: if (!bus.en_stage) begin
                state_d = IDLE;
                flush   = 1'b1;
            end else if (drn_q == DRN_LAST) begin
                state_d = DONE;
            end else begin
                drn_d = drn_q + 1'b1;
            end
            DONE: if (!bus.en_stage) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.ld_data) begin
            state_d = IDLE;
            flush   = 1'b1;
        end
        addr_pipe_d  = {addr_pipe_q[LAT-1:0], k_d};
        vld_pipe_d   = flush ? '0 : {vld_pipe_q[LAT-1:0], state_d == RUN};
        m0_s_d       = (state_d != IDLE);
        stage_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            drn_q        <= '0;
            m1_s_q       <= '0;
            m2_s_q       <= 1'b0;
            m0_s_q       <= 1'b0;
            stage_done_q <= 1'b0;
            addr_pipe_q  <= '0;
            vld_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            drn_q        <= drn_d;
            m1_s_q       <= m1_s_d;
            m2_s_q       <= m2_s_d;
            m0_s_q       <= m0_s_d;
            stage_done_q <= stage_done_d;
            addr_pipe_q  <= addr_pipe_d;
            vld_pipe_q   <= vld_pipe_d;
        end
    end

    assign bus.m0_s       = m0_s_q;
    assign bus.m1_s       = m1_s_q;
    assign bus.m2_s       = m2_s_q;
    assign bus.m3_s       = vld_pipe_q[LAT];
    assign bus.r_addr_0_1 = addr_pipe_q[0];
    assign bus.r_addr_2_3 = addr_pipe_q[0];
    assign bus.w_addr_0_1 = addr_pipe_q[LAT];
    assign bus.w_addr_2_3 = addr_pipe_q[LAT];
    assign bus.stage_done = stage_done_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: a per-cycle vector table for one full
// stage, then hand-written handshake, abort, load, illegal-stage and reset cases.
module tb_fft_stage_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.ADDRSIZE(3)) b ();

    fft_stage_ctrl #(.NUMSTAGES(5), .ADDRSIZE(3), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    // {m0, m1[1:0], m2, m3, r01[2:0], r23[2:0], w01[2:0], w23[2:0], done}
    logic [17:0] obs;
    assign obs = {b.m0_s, b.m1_s, b.m2_s, b.m3_s, b.r_addr_0_1, b.r_addr_2_3,
                  b.w_addr_0_1, b.w_addr_2_3, b.stage_done};

    typedef struct {
        logic       en;
        logic       m0;
        logic [2:0] r;
        logic [2:0] w;
        logic       m3;
        logic       done;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m3_tot, m3_stage, budget;
        logic seen;

        b.ld_data   = 1'b0;
        b.en_stage  = 1'b0;
        b.stage_num = 3'd0;
        #3;
        chk("reset_outputs", 32'(obs), 32'h0);
        #10;
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'(obs), 32'h0);

        // One stage 0 run, E0..E11 with en held, E12 with en dropped.
        for (int i = 0; i < 13; i++) begin
            tbl[i].en   = (i < 12);
            tbl[i].m0   = (i < 12);
            tbl[i].r    = (i < 8) ? 3'(i) : 3'd7;
            tbl[i].w    = (i < 2) ? 3'd0 : (i < 10) ? 3'(i - 2) : 3'd7;
            tbl[i].m3   = (i >= 2 && i <= 9);
            tbl[i].done = (i == 10 || i == 11);
        end
        for (int i = 0; i < 13; i++) begin
            b.en_stage  = tbl[i].en;
            b.stage_num = 3'd0;
            tick();
            chk($sformatf("stage0_E%0d", i), 32'(obs),
                32'({tbl[i].m0, 2'b00, 1'b1, tbl[i].m3, tbl[i].r, tbl[i].r,
                     tbl[i].w, tbl[i].w, tbl[i].done}));
        end

        // Five back-to-back stages with the top-level handshake.
        m3_tot = 0;
        for (int s = 0; s < 5; s++) begin
            b.en_stage  = 1'b1;
            b.stage_num = 3'(s);
            tick();
            chk($sformatf("sel_stage%0d", s), 32'({b.m1_s, b.m2_s}),
                32'({(s == 1 || s == 4) ? 2'b01 : (s == 2) ? 2'b10 : 2'b00, s < 3}));
            m3_stage = b.m3_s ? 1 : 0;
            budget = 0;
            while (!b.stage_done && budget < 30) begin
                tick();
                budget++;
                if (b.m3_s) m3_stage++;
            end
            chk($sformatf("done_latency_stage%0d", s), 32'(budget), 32'd10);
            chk($sformatf("m3_count_stage%0d", s), 32'(m3_stage), 32'd8);
            m3_tot += m3_stage;
            b.en_stage = 1'b0;
            tick();
            chk($sformatf("done_drop_stage%0d", s), 32'({b.stage_done, b.m0_s}), 32'h0);
        end
        chk("m3_total_5stages", 32'(m3_tot), 32'd40);

        // Abort by dropping en_stage at E5.
        b.en_stage  = 1'b1;
        b.stage_num = 3'd1;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_m3", 32'({b.m3_s, b.w_addr_0_1}), 32'({1'b1, 3'd2}));
        b.en_stage = 1'b0;
        tick();
        chk("abort_E5", 32'({b.m0_s, b.m3_s, b.stage_done}), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b.stage_done || b.m3_s) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'h0);

        // ld_data during DRAIN.
        b.en_stage  = 1'b1;
        b.stage_num = 3'd2;
        for (int i = 0; i < 9; i++) tick();
        chk("drain_pre_ld", 32'({b.m0_s, b.m3_s, b.w_addr_0_1, b.r_addr_0_1}),
            32'({1'b1, 1'b1, 3'd6, 3'd7}));
        b.ld_data = 1'b1;
        tick();
        chk("ld_in_drain", 32'({b.m0_s, b.m3_s, b.stage_done}), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b.m0_s || b.m3_s || b.stage_done) seen = 1'b1;
        end
        chk("ld_no_restart", 32'(seen), 32'h0);
        b.ld_data   = 1'b0;
        b.stage_num = 3'd3;
        tick();
        chk("restart_after_ld", 32'({b.m0_s, b.m1_s, b.m2_s, b.r_addr_0_1}),
            32'({1'b1, 2'b00, 1'b0, 3'd0}));
        b.en_stage = 1'b0;
        tick();
        chk("abort_restart", 32'(b.m0_s), 32'h0);

        // Illegal stage number.
        b.en_stage  = 1'b1;
        b.stage_num = 3'd6;
        tick();
        chk("illegal_E0", 32'({b.stage_done, b.m3_s, b.m1_s, b.m2_s}),
            32'({1'b1, 1'b0, 2'b00, 1'b1}));
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b.m3_s || !b.stage_done) seen = 1'b1;
        end
        chk("illegal_hold", 32'(seen), 32'h0);
        b.en_stage = 1'b0;
        tick();
        chk("illegal_release", 32'({b.stage_done, b.m0_s}), 32'h0);

        // Asynchronous reset mid-RUN.
        b.en_stage  = 1'b1;
        b.stage_num = 3'd4;
        for (int i = 0; i < 5; i++) tick();
        chk("run_pre_reset", 32'({b.m3_s, b.r_addr_0_1, b.m1_s}),
            32'({1'b1, 3'd4, 2'b01}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 32'(obs), 32'h0);
        b.en_stage = 1'b0;
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b.stage_done || b.m3_s || b.m0_s) seen = 1'b1;
        end
        chk("post_reset_idle", 32'(seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
